// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: state encoding, word/count widths and the default
// idle level of MISO. The SPI master imports the same package so both sides
// agree on encodings.
package spi_slave_pkg;

  localparam int WORD_W = 32;  // data word width
  localparam int CNT_W  = 6;   // bit-count width (count minus 1, plus headroom)

  // FSM encoding kept as plain 2-bit constants for legacy compatibility.
  localparam logic [1:0] ST_WAIT_HIGH = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  localparam logic DEFAULT_IDLE = 1'b1;

  // Received bit count (1..33, saturating) to "count minus 1" capped at 31.
  function automatic logic [CNT_W-1:0] rx_count_to_nbits(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] sat;
    sat = (cnt > 6'd32) ? 6'd32 : cnt;
    return sat - 6'd1;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage synchronizer for one asynchronous input.
// Ports: clk, nrst (async active-low), d (async input), q (synchronized).
// RST_VAL sets the value every stage takes during reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 responder (SCK idles high, CSN active low, MSB first).
// SPI pins are oversampled by clk and exposed as parallel words.
// Ports:
//   clk, nrst                 fabric clock, async active-low reset
//   spi_csn/spi_sck/spi_mosi  async SPI inputs from the master
//   spi_miso                  registered slave-out data
//   tx_data/tx_nbits/tx_valid/tx_ready  TX word offer (right-aligned, count-1)
//   rx_data/rx_nbits/rx_valid/rx_overrun received word, pulse on CSN rise
//   tx_underrun               pulse: transfer began with no TX word loaded
//
// Handshake: a TX word is accepted in any cycle where tx_valid and tx_ready
// are both high at the clock edge; tx_ready stays low until the word is
// consumed by the next CSN fall. RX has no backpressure: rx_valid is a
// one-cycle pulse and rx_data/rx_nbits/rx_overrun hold until the next pulse.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic MISO_IDLE   = DEFAULT_IDLE,
  parameter logic MISO_FILL   = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              spi_csn,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [WORD_W-1:0] tx_data,
  input  logic [CNT_W-1:0]  tx_nbits,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic [CNT_W-1:0]  rx_nbits,
  output logic              rx_valid,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  // After reset the synchronizer chains still hold their reset values for
  // SYNC_STAGES cycles, plus one for the delay flop. WAIT_HIGH waits this out
  // so a CSN that is already low at reset release is not mistaken for a fresh
  // CSN fall.
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FW    = $clog2(FLUSH + 1);

  logic csn_s, sck_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .nrst(nrst), .d(spi_csn), .q(csn_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .nrst(nrst), .d(spi_sck), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .nrst(nrst), .d(spi_mosi), .q(mosi_s));

  // Bit 5 of tx_nbits carries no meaning; the count is taken from [4:0].
  logic unused_nbits_msb;
  assign unused_nbits_msb = tx_nbits[5];

  logic [1:0]        state_q, state_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              csn_dly_q, csn_dly_d;
  logic              sck_dly_q, sck_dly_d;
  logic              hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic [4:0]        hold_nbits_q, hold_nbits_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]  tx_left_q, tx_left_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              seen_rise_q, seen_rise_d;
  logic              miso_q, miso_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  rx_nbits_q, rx_nbits_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;

  logic csn_fall, csn_rise, sck_fall, sck_rise;

  assign csn_fall = csn_dly_q & ~csn_s;
  assign csn_rise = ~csn_dly_q & csn_s;
  assign sck_fall = sck_dly_q & ~sck_s;
  assign sck_rise = ~sck_dly_q & sck_s;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    csn_dly_d     = csn_s;
    sck_dly_d     = sck_s;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    hold_nbits_d  = hold_nbits_q;
    tx_shift_d    = tx_shift_q;
    tx_left_d     = tx_left_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    seen_rise_d   = seen_rise_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_nbits_d    = rx_nbits_q;
    rx_valid_d    = 1'b0;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = 1'b0;

    // Consumption comes first so a word offered in the CSN-fall cycle is kept
    // for the following transfer.
    if (state_q == ST_IDLE && csn_fall) begin
      hold_valid_d = 1'b0;
    end
    if (tx_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
      hold_nbits_d = tx_nbits[4:0];
    end

    case (state_q)
      ST_WAIT_HIGH: begin
        miso_d = MISO_IDLE;
        if (flush_cnt_q != FW'(FLUSH)) begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end else if (csn_s && csn_dly_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        miso_d = MISO_IDLE;
        if (csn_fall) begin
          if (hold_valid_q) begin
            // MSB-align the word so shift[31] is always the next bit out.
            tx_shift_d = hold_data_q << (5'd31 - hold_nbits_q);
            tx_left_d  = {1'b0, hold_nbits_q} + 6'd1;
          end else begin
            tx_shift_d    = {WORD_W{MISO_FILL}};
            tx_left_d     = '0;
            tx_underrun_d = 1'b1;
          end
          // First bit is presented now; the master samples it on the first
          // SCK rise, so any SCK fall before that rise is ignored.
          miso_d      = tx_shift_d[WORD_W-1];
          rx_shift_d  = '0;
          bit_cnt_d   = '0;
          seen_rise_d = 1'b0;
          state_d     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (csn_rise) begin
          // End of transfer wins over any SCK edge seen in the same cycle.
          if (bit_cnt_q != '0) begin
            rx_data_d    = rx_shift_q;
            rx_nbits_d   = rx_count_to_nbits(bit_cnt_q);
            rx_overrun_d = (bit_cnt_q > 6'd32);
            rx_valid_d   = 1'b1;
          end
          miso_d  = MISO_IDLE;
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          rx_shift_d  = {rx_shift_q[WORD_W-2:0], mosi_s};
          seen_rise_d = 1'b1;
          if (bit_cnt_q != 6'd33) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else if (sck_fall && seen_rise_q) begin
          tx_shift_d = {tx_shift_q[WORD_W-2:0], MISO_FILL};
          if (tx_left_q != '0) begin
            tx_left_d = tx_left_q - 6'd1;
          end
          // Once the word is exhausted the zeros left by the alignment shift
          // must not leak out; drive the fill level instead.
          miso_d = (tx_left_d == '0) ? MISO_FILL : tx_shift_d[WORD_W-1];
        end
      end

      default: begin
        state_d = ST_WAIT_HIGH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_WAIT_HIGH;
      flush_cnt_q   <= '0;
      csn_dly_q     <= 1'b1;
      sck_dly_q     <= 1'b1;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      hold_nbits_q  <= '0;
      tx_shift_q    <= '0;
      tx_left_q     <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      seen_rise_q   <= 1'b0;
      miso_q        <= MISO_IDLE;
      rx_data_q     <= '0;
      rx_nbits_q    <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      csn_dly_q     <= csn_dly_d;
      sck_dly_q     <= sck_dly_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      hold_nbits_q  <= hold_nbits_d;
      tx_shift_q    <= tx_shift_d;
      tx_left_q     <= tx_left_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      seen_rise_q   <= seen_rise_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_nbits_q    <= rx_nbits_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign spi_miso    = miso_q;
  assign tx_ready    = ~hold_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_nbits    = rx_nbits_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: the bench plays the SPI master (mode 3, SCK half
// period HALF clk cycles) and checks received words, MISO bit streams and
// the TX/RX handshake pulses against hand-computed vectors.
module tb_spi_slave;

  localparam int HALF = 8;

  logic        clk;
  logic        nrst;
  logic        spi_csn;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] tx_data;
  logic [5:0]  tx_nbits;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic [5:0]  rx_nbits;
  logic        rx_valid;
  logic        rx_overrun;
  logic        tx_underrun;

  spi_slave dut (
    .clk(clk), .nrst(nrst),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_nbits(tx_nbits), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_nbits(rx_nbits), .rx_valid(rx_valid),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor: counts rx_valid/tx_underrun pulses and captures the RX word.
  int          vcnt = 0;
  int          ucnt = 0;
  logic [31:0] cap_data  = '0;
  logic [5:0]  cap_nbits = '0;
  logic        cap_ovr   = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      cap_data  = rx_data;
      cap_nbits = rx_nbits;
      cap_ovr   = rx_overrun;
    end
    if (tx_underrun) ucnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [31:0] d, input logic [5:0] n);
    @(negedge clk);
    tx_data  = d;
    tx_nbits = n;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One mode-3 transfer of n bits, MSB first. MISO is sampled just before
  // each SCK rise and collected right-aligned in sbits.
  task automatic spi_xfer(input logic [63:0] mbits, input int n, output logic [63:0] sbits);
    sbits = '0;
    @(negedge clk);
    spi_csn = 1'b0;
    wait_cycles(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = mbits[i];
      wait_cycles(HALF);
      sbits   = {sbits[62:0], spi_miso};
      spi_sck = 1'b1;
      wait_cycles(HALF);
    end
    spi_csn = 1'b1;
    wait_cycles(HALF);
    spi_mosi = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        load;
    logic [31:0] tx_data;
    logic [5:0]  tx_nbits;
    logic [63:0] mosi;
    int          nbits;
    logic [31:0] exp_rx;
    logic [5:0]  exp_rx_nbits;
    logic        exp_ovr;
    logic [63:0] exp_miso;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs[NVEC];

  logic [63:0] sbits;
  int          v0, u0;

  initial begin
    // load, tx_data, tx_nbits, mosi, nbits, exp_rx, exp_rx_nbits, exp_ovr, exp_miso
    vecs[0] = '{1'b1, 32'h3C,       6'd7,  64'hA5,         8,  32'hA5,       6'd7,  1'b0, 64'h3C};
    vecs[1] = '{1'b1, 32'hDEADBEEF, 6'd31, 64'hDEADBEEF,   32, 32'hDEADBEEF, 6'd31, 1'b0, 64'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h0,        6'd0,  64'h5A,         8,  32'h5A,       6'd7,  1'b0, 64'hFF};
    vecs[3] = '{1'b1, 32'h0,        6'd0,  64'h1,          1,  32'h1,        6'd0,  1'b0, 64'h0};
    vecs[4] = '{1'b1, 32'h2,        6'd1,  64'h2B,         6,  32'h2B,       6'd5,  1'b0, 64'h2F};
    vecs[5] = '{1'b1, 32'hABCD,     6'd15, 64'h81,         8,  32'h81,       6'd7,  1'b0, 64'hAB};
    vecs[6] = '{1'b1, 32'h1C3,      6'h27, 64'h3C,         8,  32'h3C,       6'd7,  1'b0, 64'hC3};
    vecs[7] = '{1'b1, 32'h12345678, 6'd31, 64'hA1B2C3D4E5, 40, 32'hB2C3D4E5, 6'd31, 1'b1, 64'h12345678FF};

    // ---------------- reset ----------------
    nrst     = 1'b0;
    spi_csn  = 1'b1;
    spi_sck  = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = '0;
    tx_nbits = '0;
    tx_valid = 1'b0;
    wait_cycles(3);
    check("rst_miso",      64'(spi_miso),    64'h1);
    check("rst_tx_ready",  64'(tx_ready),    64'h1);
    check("rst_rx_data",   64'(rx_data),     64'h0);
    check("rst_rx_nbits",  64'(rx_nbits),    64'h0);
    check("rst_rx_valid",  64'(rx_valid),    64'h0);
    check("rst_rx_ovr",    64'(rx_overrun),  64'h0);
    check("rst_underrun",  64'(tx_underrun), 64'h0);
    nrst = 1'b1;
    wait_cycles(10);

    // ---------------- table-driven transfers ----------------
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].load) load_tx(vecs[i].tx_data, vecs[i].tx_nbits);
      check($sformatf("v%0d_tx_ready_pre", i), 64'(tx_ready), 64'(!vecs[i].load));
      v0 = vcnt;
      u0 = ucnt;
      spi_xfer(vecs[i].mosi, vecs[i].nbits, sbits);
      wait_cycles(HALF);
      check($sformatf("v%0d_rx_valid_cnt", i), 64'(vcnt - v0), 64'd1);
      check($sformatf("v%0d_rx_data", i),      64'(cap_data),  64'(vecs[i].exp_rx));
      check($sformatf("v%0d_rx_nbits", i),     64'(cap_nbits), 64'(vecs[i].exp_rx_nbits));
      check($sformatf("v%0d_rx_overrun", i),   64'(cap_ovr),   64'(vecs[i].exp_ovr));
      check($sformatf("v%0d_miso_bits", i),    sbits,          vecs[i].exp_miso);
      check($sformatf("v%0d_underrun_cnt", i), 64'(ucnt - u0), 64'(!vecs[i].load));
      check($sformatf("v%0d_tx_ready_post", i), 64'(tx_ready), 64'h1);
      check($sformatf("v%0d_miso_idle", i),    64'(spi_miso),  64'h1);
      check($sformatf("v%0d_rx_data_hold", i), 64'(rx_data),   64'(vecs[i].exp_rx));
    end

    // ---------------- CSN pulse with no SCK: underrun, no rx_valid ----------
    v0 = vcnt;
    u0 = ucnt;
    @(negedge clk);
    spi_csn = 1'b0;
    wait_cycles(HALF);
    spi_csn = 1'b1;
    wait_cycles(2 * HALF);
    check("empty_xfer_rx_valid_cnt", 64'(vcnt - v0), 64'd0);
    check("empty_xfer_underrun_cnt", 64'(ucnt - u0), 64'd1);

    // ---------------- reset in the middle of a transfer ----------------
    load_tx(32'hF0, 6'd7);
    check("mid_rst_tx_ready_pre", 64'(tx_ready), 64'h0);
    v0 = vcnt;
    @(negedge clk);
    spi_csn = 1'b0;
    wait_cycles(HALF);
    for (int i = 0; i < 5; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = i[0];
      wait_cycles(HALF);
      spi_sck = 1'b1;
      wait_cycles(HALF);
    end
    nrst = 1'b0;
    wait_cycles(2);
    check("mid_rst_miso",     64'(spi_miso),   64'h1);
    check("mid_rst_tx_ready", 64'(tx_ready),   64'h1);
    check("mid_rst_rx_data",  64'(rx_data),    64'h0);
    check("mid_rst_rx_nbits", 64'(rx_nbits),   64'h0);
    check("mid_rst_rx_ovr",   64'(rx_overrun), 64'h0);
    nrst = 1'b1;
    // Rest of the interrupted transfer, CSN still low.
    for (int i = 0; i < 3; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = 1'b1;
      wait_cycles(HALF);
      spi_sck = 1'b1;
      wait_cycles(HALF);
    end
    spi_csn = 1'b1;
    wait_cycles(2 * HALF);
    check("mid_rst_no_rx_valid", 64'(vcnt - v0), 64'd0);
    check("mid_rst_rx_data_after", 64'(rx_data), 64'h0);

    // Next full transfer after CSN returned high.
    load_tx(32'h9A, 6'd7);
    v0 = vcnt;
    spi_xfer(64'h6E, 8, sbits);
    wait_cycles(HALF);
    check("post_rst_rx_valid_cnt", 64'(vcnt - v0), 64'd1);
    check("post_rst_rx_data",      64'(cap_data),  64'h6E);
    check("post_rst_rx_nbits",     64'(cap_nbits), 64'd7);
    check("post_rst_miso_bits",    sbits,          64'h9A);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
